// File: rtl/gmii_video_rx_parser.sv
// GMII receive parser for one partial video line per Ethernet frame.
// Emits one line-FIFO write per RGB pixel and counts good and aborted frames.
module gmii_video_rx_parser #(
  parameter logic [15:0] ETHERTYPE = 16'h3776,
  parameter logic [11:0] NPIX      = 12'd640
) (
  input  logic        clk125m,
  input  logic        reset,
  input  logic        gmii_rxdv,
  input  logic        gmii_rxer,
  input  logic [7:0]  gmii_rxd,
  input  logic        fifo_full,
  output logic        fifo_wr_en,
  output logic [11:0] y_din,
  output logic [11:0] x_din,
  output logic [23:0] pix_din,
  output logic [15:0] pkt_ok_cnt,
  output logic [15:0] err_cnt
);

  typedef enum logic [2:0] {IDLE, PRE, HDR, VHDR, PIX, DROP} state_t;

  state_t      state, state_nx;
  logic        rxdv_q, rxer_q;
  logic [7:0]  rxd_q;
  logic [3:0]  bcnt, bcnt_nx;
  logic [1:0]  phase, phase_nx;
  logic [11:0] pcnt, pcnt_nx;
  logic [11:0] y_reg, y_nx, x_reg, x_nx;
  logic [7:0]  r_reg, r_nx, g_reg, g_nx, eth_hi, eth_hi_nx;
  logic        wr, ok_inc, err_inc;

  always_comb begin
    state_nx  = state;
    bcnt_nx   = bcnt;
    phase_nx  = phase;
    pcnt_nx   = pcnt;
    y_nx      = y_reg;
    x_nx      = x_reg;
    r_nx      = r_reg;
    g_nx      = g_reg;
    eth_hi_nx = eth_hi;
    wr        = 1'b0;
    ok_inc    = 1'b0;
    err_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (rxdv_q) state_nx = (rxd_q == 8'h55) ? PRE : DROP;
      end
      PRE: begin
        if (!rxdv_q) begin
          state_nx = IDLE;
          err_inc  = 1'b1;
        end else if (rxer_q || (rxd_q != 8'h55 && rxd_q != 8'hD5)) begin
          state_nx = DROP;
          err_inc  = 1'b1;
        end else if (rxd_q == 8'hD5) begin
          state_nx = HDR;
          bcnt_nx  = 4'd0;
        end
      end
      HDR: begin
        if (!rxdv_q) begin
          state_nx = IDLE;
          err_inc  = 1'b1;
        end else if (rxer_q) begin
          state_nx = DROP;
          err_inc  = 1'b1;
        end else begin
          bcnt_nx = bcnt + 4'd1;
          if (bcnt == 4'd12) eth_hi_nx = rxd_q;
          // A foreign ethertype is not an error, just traffic for someone else.
          if (bcnt == 4'd13) begin
            bcnt_nx  = 4'd0;
            state_nx = ({eth_hi, rxd_q} == ETHERTYPE) ? VHDR : DROP;
          end
        end
      end
      VHDR: begin
        if (!rxdv_q) begin
          state_nx = IDLE;
          err_inc  = 1'b1;
        end else if (rxer_q) begin
          state_nx = DROP;
          err_inc  = 1'b1;
        end else begin
          bcnt_nx = bcnt + 4'd1;
          case (bcnt[1:0])
            2'd0: y_nx[11:8] = rxd_q[3:0];
            2'd1: y_nx[7:0]  = rxd_q;
            2'd2: x_nx[11:8] = rxd_q[3:0];
            default: begin
              x_nx[7:0] = rxd_q;
              state_nx  = PIX;
              phase_nx  = 2'd0;
              pcnt_nx   = 12'd0;
            end
          endcase
        end
      end
      PIX: begin
        if (!rxdv_q) begin
          // Trailing partial pixel is discarded; any complete pixel makes it a good frame.
          state_nx = IDLE;
          ok_inc   = (pcnt != 12'd0);
          err_inc  = (pcnt == 12'd0);
        end else if (rxer_q) begin
          state_nx = DROP;
          err_inc  = 1'b1;
        end else begin
          case (phase)
            2'd0: begin
              r_nx     = rxd_q;
              phase_nx = 2'd1;
            end
            2'd1: begin
              g_nx     = rxd_q;
              phase_nx = 2'd2;
            end
            default: begin
              phase_nx = 2'd0;
              if (fifo_full) begin
                state_nx = DROP;
                err_inc  = 1'b1;
              end else begin
                wr      = 1'b1;
                x_nx    = x_reg + 12'd1;
                pcnt_nx = pcnt + 12'd1;
                if (pcnt + 12'd1 == NPIX) begin
                  state_nx = DROP;
                  ok_inc   = 1'b1;
                end
              end
            end
          endcase
        end
      end
      default: begin
        if (!rxdv_q) state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk125m) begin
    if (reset) begin
      rxdv_q     <= 1'b0;
      rxer_q     <= 1'b0;
      rxd_q      <= 8'd0;
      state      <= IDLE;
      bcnt       <= 4'd0;
      phase      <= 2'd0;
      pcnt       <= 12'd0;
      fifo_wr_en <= 1'b0;
      y_din      <= 12'd0;
      x_din      <= 12'd0;
      pix_din    <= 24'd0;
      pkt_ok_cnt <= 16'd0;
      err_cnt    <= 16'd0;
    end else begin
      rxdv_q     <= gmii_rxdv;
      rxer_q     <= gmii_rxer;
      rxd_q      <= gmii_rxd;
      state      <= state_nx;
      bcnt       <= bcnt_nx;
      phase      <= phase_nx;
      pcnt       <= pcnt_nx;
      fifo_wr_en <= wr;
      if (wr) begin
        y_din   <= y_reg;
        x_din   <= x_reg;
        pix_din <= {r_reg, g_reg, rxd_q};
      end
      pkt_ok_cnt <= pkt_ok_cnt + {15'd0, ok_inc};
      err_cnt    <= err_cnt + {15'd0, err_inc};
    end
  end

  always_ff @(posedge clk125m) begin
    y_reg  <= y_nx;
    x_reg  <= x_nx;
    r_reg  <= r_nx;
    g_reg  <= g_nx;
    eth_hi <= eth_hi_nx;
  end

endmodule

// File: tb/tb_gmii_video_rx_parser.sv
// Scoreboard bench for gmii_video_rx_parser: frames are generated, a frame-level model
// queues the expected pixel writes and counter totals, a monitor checks every write.
module tb_gmii_video_rx_parser;

  localparam int TB_NPIX = 4;

  logic        clk125m = 1'b0;
  logic        reset;
  logic        gmii_rxdv, gmii_rxer, fifo_full;
  logic [7:0]  gmii_rxd;
  logic        fifo_wr_en;
  logic [11:0] y_din, x_din;
  logic [23:0] pix_din;
  logic [15:0] pkt_ok_cnt, err_cnt;

  int          checks = 0;
  int          failures = 0;
  int          exp_ok = 0;
  int          exp_err = 0;
  logic [47:0] exp_q[$];
  logic [7:0]  fr[$];
  logic [23:0] pxq[$];

  gmii_video_rx_parser #(.ETHERTYPE(16'h3776), .NPIX(12'd4)) dut (
    .clk125m(clk125m), .reset(reset), .gmii_rxdv(gmii_rxdv), .gmii_rxer(gmii_rxer),
    .gmii_rxd(gmii_rxd), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .y_din(y_din),
    .x_din(x_din), .pix_din(pix_din), .pkt_ok_cnt(pkt_ok_cnt), .err_cnt(err_cnt)
  );

  always #4 clk125m = ~clk125m;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic check_cnt(input string tag);
    logic [15:0] eo, ee;
    eo = exp_ok[15:0];
    ee = exp_err[15:0];
    check({tag, " pkt_ok_cnt"}, {32'd0, pkt_ok_cnt}, {32'd0, eo});
    check({tag, " err_cnt"}, {32'd0, err_cnt}, {32'd0, ee});
  endtask

  always @(negedge clk125m) begin
    if (!reset && fifo_wr_en) begin
      if (exp_q.size() == 0) check("unexpected_write", {y_din, x_din, pix_din}, 48'd0);
      else check("pixel_write", {y_din, x_din, pix_din}, exp_q.pop_front());
    end
  end

  task automatic build(input int pre_len, input logic [15:0] eth, input logic [7:0] yh,
                       input logic [7:0] yl, input logic [7:0] xh, input logic [7:0] xl,
                       input int npx, input int nfcs, input bit bad_pre);
    logic [23:0] px;
    fr.delete();
    repeat (pre_len) fr.push_back(8'h55);
    fr.push_back(bad_pre ? 8'h5A : 8'hD5);
    repeat (12) fr.push_back(8'($urandom_range(0, 255)));
    fr.push_back(eth[15:8]);
    fr.push_back(eth[7:0]);
    fr.push_back(yh); fr.push_back(yl); fr.push_back(xh); fr.push_back(xl);
    for (int p = 0; p < npx; p++) begin
      px = (pxq.size() != 0) ? pxq.pop_front() : 24'($urandom);
      fr.push_back(px[23:16]); fr.push_back(px[15:8]); fr.push_back(px[7:0]);
    end
    repeat (nfcs) fr.push_back(8'($urandom_range(0, 255)));
  endtask

  // Frame-level outcome: bytes seen before an abort, whole pixels among them, first event wins.
  task automatic model(input int pre_len, input int len, input int e, input int j, input bit bad_pre);
    int d, p0, avail, nc, nw;
    logic [11:0] y, x;
    d  = pre_len + 1;
    p0 = d + 18;
    avail = (e >= 0 && e < len) ? e : len;
    if (bad_pre) begin
      exp_err++;
      return;
    end
    if ({fr[d+12], fr[d+13]} != 16'h3776) return;
    y  = {fr[d+14][3:0], fr[d+15]};
    x  = {fr[d+16][3:0], fr[d+17]};
    nc = (avail > p0) ? (avail - p0) / 3 : 0;
    if (nc > TB_NPIX) nc = TB_NPIX;
    nw = (j >= 0 && j < nc) ? j : nc;
    for (int p = 0; p < nw; p++)
      exp_q.push_back({y, 12'(x + 12'(p)), fr[p0+3*p], fr[p0+3*p+1], fr[p0+3*p+2]});
    if (nw < nc) exp_err++;
    else if (nc == TB_NPIX) exp_ok++;
    else if (avail < len) exp_err++;
    else if (nc >= 1) exp_ok++;
    else exp_err++;
  endtask

  task automatic send(input int len, input int e, input int full_from, input int ifg);
    for (int i = 0; i < len; i++) begin
      @(posedge clk125m); #1;
      gmii_rxdv = 1'b1;
      gmii_rxd  = fr[i];
      gmii_rxer = (i == e);
      if (full_from >= 0 && i >= full_from) fifo_full = 1'b1;
    end
    for (int k = 0; k < ifg; k++) begin
      @(posedge clk125m); #1;
      gmii_rxdv = 1'b0;
      gmii_rxer = 1'b0;
      gmii_rxd  = 8'($urandom_range(0, 255));
    end
    fifo_full = 1'b0;
  endtask

  task automatic run_frame(input string tag, input int pre_len, input logic [15:0] eth,
                           input logic [7:0] yh, input logic [7:0] yl, input logic [7:0] xh,
                           input logic [7:0] xl, input int npx, input int nfcs, input bit bad_pre,
                           input int trunc, input int e, input int j, input int ifg);
    int len, full_from;
    build(pre_len, eth, yh, yl, xh, xl, npx, nfcs, bad_pre);
    len = (trunc < 0) ? fr.size() : trunc;
    full_from = (j >= 0) ? pre_len + 19 + 3 * j + 1 : -1;
    model(pre_len, len, e, j, bad_pre);
    send(len, e, full_from, ifg);
    if (ifg >= 3) check_cnt(tag);
  endtask

  initial begin
    int pre, npx, nfcs, ft, tr, e, j, ifg, len;
    logic [15:0] eth;
    logic [7:0]  xh, xl;
    bit bad;

    reset = 1'b1; gmii_rxdv = 1'b0; gmii_rxer = 1'b0; gmii_rxd = 8'h00; fifo_full = 1'b0;
    repeat (3) @(posedge clk125m);
    #1;
    check("reset fifo_wr_en", {47'd0, fifo_wr_en}, 48'd0);
    check("reset y_x_pix", {y_din, x_din, pix_din}, 48'd0);
    check_cnt("reset");
    reset = 1'b0;

    pxq.push_back(24'h112233); pxq.push_back(24'h445566);
    run_frame("T1", 7, 16'h3776, 8'h00, 8'h1E, 8'h00, 8'h00, 2, 0, 0, -1, -1, -1, 4);
    run_frame("T2", 7, 16'h3776, 8'h00, 8'h10, 8'h00, 8'h00, 6, 4, 0, -1, -1, -1, 4);
    run_frame("T3a", 7, 16'h0800, 8'h00, 8'h20, 8'h00, 8'h00, 2, 4, 0, -1, -1, -1, 1);
    run_frame("T3b", 3, 16'h3776, 8'h00, 8'h21, 8'h00, 8'h05, 3, 4, 0, -1, -1, -1, 4);
    run_frame("T4", 7, 16'h3776, 8'h00, 8'h30, 8'h00, 8'h00, 3, 4, 0, -1, 30, -1, 4);
    run_frame("T5", 7, 16'h3776, 8'h00, 8'h40, 8'h00, 8'h00, 4, 4, 0, -1, -1, 2, 4);
    run_frame("T6a", 7, 16'h3776, 8'h00, 8'h50, 8'h00, 8'h00, 3, 4, 0, 26, -1, -1, 4);
    run_frame("wrap", 1, 16'h3776, 8'hA1, 8'h23, 8'hFF, 8'hFE, 4, 0, 0, -1, -1, -1, 4);

    // Reset while pixel 1 is arriving; the remaining bytes start with a non-preamble byte.
    pxq.push_back(24'hA1A2A3); pxq.push_back(24'hB1B2B3); pxq.push_back(24'h778899);
    build(7, 16'h3776, 8'h00, 8'h05, 8'h00, 8'h03, 3, 4, 0);
    exp_q.push_back({12'h005, 12'h003, 24'hA1A2A3});
    for (int i = 0; i < fr.size(); i++) begin
      @(posedge clk125m); #1;
      if (i == 32) begin
        check("T6b reset fifo_wr_en", {47'd0, fifo_wr_en}, 48'd0);
        check("T6b reset y_x_pix", {y_din, x_din, pix_din}, 48'd0);
        exp_ok = 0;
        exp_err = 0;
        check_cnt("T6b reset");
      end
      reset = (i == 31);
      gmii_rxdv = 1'b1;
      gmii_rxd  = fr[i];
    end
    send(0, -1, -1, 4);
    check_cnt("T6b tail");
    run_frame("T6c", 5, 16'h3776, 8'h00, 8'h60, 8'h00, 8'h00, 2, 4, 0, -1, -1, -1, 4);

    for (int n = 0; n < 150; n++) begin
      pre = $urandom_range(1, 7); npx = $urandom_range(0, 6); nfcs = $urandom_range(0, 4);
      ft = $urandom_range(0, 5); eth = 16'h3776; bad = 1'b0; tr = -1; e = -1; j = -1;
      len = pre + 19 + 3 * npx + nfcs;
      xh = 8'($urandom_range(0, 255)); xl = 8'($urandom_range(0, 255));
      case (ft)
        1: bad = 1'b1;
        2: begin
          eth = 16'($urandom);
          if (eth == 16'h3776) eth = 16'h3777;
        end
        3: tr = $urandom_range(pre + 2, len);
        4: e = $urandom_range(1, len - 1);
        5: j = $urandom_range(0, 5);
        default: ;
      endcase
      ifg = $urandom_range(1, 4);
      run_frame("rand", pre, eth, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                xh, xl, npx, nfcs, bad, tr, e, j, ifg);
    end

    send(0, -1, -1, 6);
    check("pending writes", 48'(exp_q.size()), 48'd0);
    check_cnt("final");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
